// File: rtl/multdiv_unit.sv
// multdiv_unit: iterative radix-2 shift-add multiply / restoring divide, signed or unsigned, with tag passthrough and flush.
// Latency: fixed WIDTH+1 cycles from accepting edge to the result_valid cycle; optional remainder port under MULTDIV_REM_EN.
// Backpressure: none; starts are ignored while busy, and the processor stalls on busy.
module multdiv_unit #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic             op_signed,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             busy,
  output logic             result_valid,
  output logic [WIDTH-1:0] result,
  output logic             exception,
  output logic [TAG_W-1:0] out_tag
`ifdef MULTDIV_REM_EN
  ,
  output logic [WIDTH-1:0] remainder
`endif
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_n;
  logic             accept;
  logic [CW-1:0]    cnt;
  logic             is_div, sgn, neg_res, div0;
  logic [WIDTH-1:0] dv, hi, lo;
  logic [TAG_W-1:0] tag;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  logic [WIDTH:0]     msum, dshift;
  logic [WIDTH-1:0]   dsub, hi_step, lo_step;
  logic               dge;
  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0]   quo;
  logic               mul_exc, div_exc;

  assign a_neg = op_signed & operand_a[WIDTH-1];
  assign b_neg = op_signed & operand_b[WIDTH-1];
  assign a_mag = a_neg ? -operand_a : operand_a;
  assign b_mag = b_neg ? -operand_b : operand_b;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    case (state)
      IDLE: if (!flush && (start_mult ^ start_div)) begin
        state_n = RUN;
        accept  = 1'b1;
      end
      RUN: begin
        if (flush)                      state_n = IDLE;
        else if (cnt == CW'(WIDTH - 1)) state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // {hi,lo} is the 2*WIDTH accumulator: product for multiply, {partial remainder, dividend/quotient} for divide
  always_comb begin
    msum    = {1'b0, hi} + (lo[0] ? {1'b0, dv} : '0);
    dshift  = {hi, lo[WIDTH-1]};
    dge     = (dshift >= {1'b0, dv});
    dsub    = dshift[WIDTH-1:0] - dv;
    hi_step = msum[WIDTH:1];
    lo_step = {msum[0], lo[WIDTH-1:1]};
    if (is_div) begin
      hi_step = dge ? dsub : dshift[WIDTH-1:0];
      lo_step = {lo[WIDTH-2:0], dge};
    end
  end

  assign prod    = {hi_step, lo_step};
  assign prod_s  = neg_res ? -prod : prod;
  assign mul_exc = sgn ? (prod_s[2*WIDTH-1:WIDTH] != {WIDTH{prod_s[WIDTH-1]}})
                       : (prod[2*WIDTH-1:WIDTH] != '0);
  assign quo     = neg_res ? -lo_step : lo_step;
  // A positive signed quotient with the top bit set can only come from MIN / -1
  assign div_exc = div0 | (sgn & ~neg_res & lo_step[WIDTH-1]);

`ifdef MULTDIV_REM_EN
  logic             neg_rem;
  logic [WIDTH-1:0] rem;
  assign rem = neg_rem ? -hi_step : hi_step;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt          <= '0;
      is_div       <= 1'b0;
      sgn          <= 1'b0;
      neg_res      <= 1'b0;
      div0         <= 1'b0;
      dv           <= '0;
      hi           <= '0;
      lo           <= '0;
      tag          <= '0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      result       <= '0;
      exception    <= 1'b0;
      out_tag      <= '0;
`ifdef MULTDIV_REM_EN
      neg_rem      <= 1'b0;
      remainder    <= '0;
`endif
    end else begin
      if (accept) begin
        is_div  <= start_div;
        sgn     <= op_signed;
        neg_res <= a_neg ^ b_neg;
        div0    <= start_div & (operand_b == '0);
        tag     <= in_tag;
        cnt     <= '0;
        hi      <= '0;
        dv      <= start_div ? b_mag : a_mag;
        lo      <= start_div ? a_mag : b_mag;
`ifdef MULTDIV_REM_EN
        neg_rem <= a_neg;
`endif
      end else if (state == RUN) begin
        hi  <= hi_step;
        lo  <= lo_step;
        cnt <= cnt + CW'(1);
      end
      busy         <= (state_n != IDLE);
      result_valid <= (state_n == DONE);
      if (state == RUN && state_n == DONE) begin
        result    <= is_div ? (div0 ? '0 : quo) : prod_s[WIDTH-1:0];
        exception <= is_div ? div_exc : mul_exc;
        out_tag   <= tag;
`ifdef MULTDIV_REM_EN
        remainder <= is_div ? rem : '0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_multdiv_unit.sv
// Bench for multdiv_unit at WIDTH=32: directed vector table, corner sequences, and randomized ops against an arithmetic model.
module tb_multdiv_unit;
  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         start_mult = 1'b0, start_div = 1'b0, op_signed = 1'b0, flush = 1'b0;
  logic [W-1:0] operand_a = '0, operand_b = '0;
  logic [4:0]   in_tag = '0;
  logic         busy, result_valid, exception;
  logic [W-1:0] result;
  logic [4:0]   out_tag;
`ifdef MULTDIV_REM_EN
  logic [W-1:0] remainder;
`endif

  always #5 clock = ~clock;

  multdiv_unit #(.WIDTH(W), .TAG_W(5)) dut (
    .clock(clock), .reset(reset), .start_mult(start_mult), .start_div(start_div),
    .op_signed(op_signed), .operand_a(operand_a), .operand_b(operand_b), .in_tag(in_tag),
    .flush(flush), .busy(busy), .result_valid(result_valid), .result(result),
    .exception(exception), .out_tag(out_tag)
`ifdef MULTDIV_REM_EN
    , .remainder(remainder)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: plain wide arithmetic on the operand values
  function automatic void model(input logic is_div, input logic sg, input logic [W-1:0] a,
                                input logic [W-1:0] b, output logic [W-1:0] r,
                                output logic e, output logic [W-1:0] rm);
    longint      sp;
    logic [63:0] up;
    rm = '0;
    e  = 1'b0;
    if (!is_div) begin
      if (sg) begin
        sp = longint'($signed(a)) * longint'($signed(b));
        r  = sp[31:0];
        e  = (sp != longint'($signed(r)));
      end else begin
        up = {32'd0, a} * {32'd0, b};
        r  = up[31:0];
        e  = (up[63:32] != 32'd0);
      end
    end else if (b == 32'd0) begin
      r = '0; e = 1'b1; rm = a;
    end else if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      r = a; e = 1'b1; rm = '0;
    end else if (sg) begin
      r  = $signed(a) / $signed(b);
      rm = $signed(a) % $signed(b);
    end else begin
      r  = a / b;
      rm = a % b;
    end
  endfunction

  // Called just after a negedge; leaves the bench at the negedge after the accepting edge T
  task automatic issue(input logic is_div, input logic sg, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [4:0] tg);
    start_mult = !is_div;
    start_div  = is_div;
    op_signed  = sg;
    operand_a  = a;
    operand_b  = b;
    in_tag     = tg;
    @(posedge clock);
    @(negedge clock);
    start_mult = 1'b0;
    start_div  = 1'b0;
  endtask

  // k counts negedges after T: sample k sees the value present at edge T+k
  task automatic check_done(input int k0, input string name, input logic [W-1:0] er,
                            input logic ee, input logic [W-1:0] erm, input logic [4:0] etag);
    logic tim_ok;
    logic exp_rv;
    tim_ok = 1'b1;
    for (int k = k0; k <= W + 1; k++) begin
      exp_rv = (k == W + 1) ? 1'b1 : 1'b0;
      if (busy !== 1'b1 || result_valid !== exp_rv) tim_ok = 1'b0;
      if (k < W + 1) @(negedge clock);
    end
    chk({name, "_timing"}, tim_ok, 1);
    chk({name, "_result"}, result, er);
    chk({name, "_exc"}, exception, ee);
    chk({name, "_tag"}, out_tag, etag);
`ifdef MULTDIV_REM_EN
    chk({name, "_rem"}, remainder, erm);
`else
    if (erm === 'x) $display("unexpected unknown remainder expectation in %s", name);
`endif
    @(negedge clock);
    chk({name, "_idle"}, {busy, result_valid}, 0);
  endtask

  typedef struct {
    logic         is_div;
    logic         sg;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] er;
    logic         ee;
    logic [W-1:0] erm;
  } vec_t;

  vec_t vecs[13];

  initial begin
    logic         d, s, ee;
    logic [W-1:0] a, b, er, erm;
    int           ra;

    vecs[0]  = '{1'b0, 1'b1, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 32'd0};
    vecs[1]  = '{1'b1, 1'b1, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0, 32'hFFFF_FFFF};
    vecs[2]  = '{1'b1, 1'b0, 32'hFFFF_FFF9,  32'd2,         32'h7FFF_FFFC, 1'b0, 32'd1};
    vecs[3]  = '{1'b1, 1'b1, 32'd5,          32'd0,         32'd0,         1'b1, 32'd5};
    vecs[4]  = '{1'b1, 1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 32'd0};
    vecs[5]  = '{1'b0, 1'b1, 32'h0001_0000,  32'h0001_0000, 32'd0,         1'b1, 32'd0};
    vecs[6]  = '{1'b0, 1'b0, 32'h0000_FFFF,  32'h0000_FFFF, 32'hFFFE_0001, 1'b0, 32'd0};
    vecs[7]  = '{1'b1, 1'b0, 32'd5,          32'd0,         32'd0,         1'b1, 32'd5};
    vecs[8]  = '{1'b0, 1'b1, 32'h8000_0000,  32'd1,         32'h8000_0000, 1'b0, 32'd0};
    vecs[9]  = '{1'b0, 1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'd1,         1'b0, 32'd0};
    vecs[10] = '{1'b0, 1'b0, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFE, 1'b1, 32'd0};
    vecs[11] = '{1'b1, 1'b1, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 32'd1};
    vecs[12] = '{1'b1, 1'b1, 32'hFFFF_FFF8,  32'hFFFF_FFFD, 32'd2,         1'b0, 32'hFFFF_FFFE};

    #1;
    chk("reset_outputs", {busy, result_valid, exception, out_tag, result}, 0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    for (int i = 0; i < 13; i++) begin
      issue(vecs[i].is_div, vecs[i].sg, vecs[i].a, vecs[i].b, 5'(i + 1));
      check_done(1, $sformatf("vec%0d", i), vecs[i].er, vecs[i].ee, vecs[i].erm, 5'(i + 1));
    end

    // Start while busy must not disturb the op in flight
    issue(1'b0, 1'b1, 32'd7, 32'hFFFF_FFFD, 5'd11);
    repeat (3) @(negedge clock);
    start_div = 1'b1; operand_a = 32'd100; operand_b = 32'd3; in_tag = 5'd22;
    @(negedge clock);
    start_div = 1'b0;
    check_done(5, "busy_start", 32'hFFFF_FFEB, 1'b0, 32'd0, 5'd11);

    start_mult = 1'b1; start_div = 1'b1;
    @(negedge clock);
    start_mult = 1'b0; start_div = 1'b0;
    chk("both_starts_ignored", busy, 0);

    flush = 1'b1; start_mult = 1'b1;
    @(negedge clock);
    flush = 1'b0; start_mult = 1'b0;
    chk("flush_beats_start", busy, 0);

    // Flush sampled at T+10; restart accepted at T+11 and completes at T+44
    issue(1'b0, 1'b0, 32'd1234, 32'd5678, 5'd3);
    repeat (9) @(negedge clock);
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    chk("flush_busy_low", {busy, result_valid}, 0);
    issue(1'b0, 1'b1, 32'd7, 32'hFFFF_FFFD, 5'd9);
    check_done(1, "after_flush", 32'hFFFF_FFEB, 1'b0, 32'd0, 5'd9);

    // Asynchronous reset between edges in the middle of a run
    issue(1'b1, 1'b0, 32'd1000, 32'd7, 5'd5);
    repeat (5) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    chk("async_reset", {busy, result_valid, exception, out_tag, result}, 0);
`ifdef MULTDIV_REM_EN
    chk("async_reset_rem", remainder, 0);
`endif
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    issue(1'b1, 1'b0, 32'd1000, 32'd7, 5'd6);
    check_done(1, "post_reset", 32'd142, 1'b0, 32'd6, 5'd6);

    for (int i = 0; i < 40; i++) begin
      d = 1'($urandom_range(0, 1));
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: begin a = $urandom; b = $urandom; end
        1: begin
          ra = int'($urandom_range(0, 40)) - 20; a = ra;
          ra = int'($urandom_range(0, 40)) - 20; b = ra;
        end
        2: begin a = $urandom; b = $urandom_range(0, 3); end
        default: begin
          a = 32'h8000_0000;
          b = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : $urandom;
        end
      endcase
      model(d, s, a, b, er, ee, erm);
      issue(d, s, a, b, 5'(i));
      check_done(1, $sformatf("rnd%0d", i), er, ee, d ? erm : 32'd0, 5'(i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
